sound_send4: RTL and testbench

- Serial transmitter for the sound path; the sending-side counterpart of the sound byte receiver (sound_store4).
- On command, it reads a block of bytes from a dual-port sample buffer through a synchronous read port.
- Each byte goes out on a single Tx line as an 8N1-style frame (start bit, 8 data bits LSB first, stop bit(s)), using the receiver's bit timing.
- It sits between the sample buffer (s_Buff-style RAM, 1-cycle read latency) and the serial line toward the far-end receiver.

---
 rtl/sound_send4.sv | 133 +++++++++++++
 tb/tb_sound_send4.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_send4.sv
// Serial byte transmitter for the sound path: reads a block from the sample
// buffer and sends each byte as a start/8 data/stop frame on Tx.
module sound_send4 #(
    parameter int length    = 48,
    parameter int stop_bits = 1,
    parameter int wrap_at   = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] start_addr,
    input  logic [10:0] count,
    output logic [10:0] rdaddress,
    input  logic [7:0]  q,
    output logic        Tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START_BIT,
        DATA,
        STOP
    } state_t;

    state_t      state, state_next;
    logic [5:0]  bit_cnt;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic [10:0] remaining;
    logic [7:0]  shift;
    logic        bit_end;
    logic        last_stop;

    assign bit_end   = (bit_cnt == 6'(length));
    assign last_stop = (stop_idx == 1'(stop_bits - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (start && count != 11'd0) state_next = FETCH;
            FETCH:     state_next = LOAD;
            LOAD:      state_next = START_BIT;
            START_BIT: if (bit_end) state_next = DATA;
            DATA:      if (bit_end && bit_idx == 3'd7) state_next = STOP;
            STOP:
                if (bit_end && last_stop)
                    state_next = (remaining == 11'd1) ? IDLE : FETCH;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdaddress <= '0;
            remaining <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            Tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    Tx <= 1'b1;
                    if (start) begin
                        if (count != 11'd0) begin
                            rdaddress <= start_addr;
                            remaining <= count;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: ;
                LOAD: begin
                    shift     <= q;
                    rdaddress <= (rdaddress == 11'(wrap_at - 1)) ? 11'd0
                                 : rdaddress + 11'd1;
                    bit_cnt   <= '0;
                    Tx        <= 1'b0;
                end
                START_BIT: begin
                    bit_cnt <= bit_end ? 6'd0 : bit_cnt + 6'd1;
                    if (bit_end) begin
                        bit_idx <= 3'd0;
                        Tx      <= shift[0];
                    end
                end
                DATA: begin
                    bit_cnt <= bit_end ? 6'd0 : bit_cnt + 6'd1;
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            Tx       <= 1'b1;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            Tx      <= shift[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    bit_cnt <= bit_end ? 6'd0 : bit_cnt + 6'd1;
                    if (bit_end) begin
                        stop_idx <= ~stop_idx;
                        // the byte is only retired once all stop periods are out
                        if (last_stop) begin
                            remaining <= remaining - 11'd1;
                            if (remaining == 11'd1) begin
                                done <= 1'b1;
                                busy <= 1'b0;
                            end
                        end
                    end
                end
                default: Tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_sound_send4.sv
// Bench for sound_send4: per-cycle waveform model built from frame rules,
// plus literal checks that pin the model and end addresses.
module tb_sound_send4;

    localparam int L  = 49;
    localparam int SB = 1;
    localparam int W  = 2000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] start_addr;
    logic [10:0] count;
    logic [10:0] rdaddress;
    logic [7:0]  q;
    logic        Tx;
    logic        busy;
    logic        done;

    sound_send4 #(.length(L - 1), .stop_bits(SB), .wrap_at(W)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .start_addr(start_addr),
        .count(count),
        .rdaddress(rdaddress),
        .q(q),
        .Tx(Tx),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    logic [7:0] ram [0:W-1];
    always @(posedge clock) q <= ram[rdaddress];

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mq[$];
    int   mq_end;
    int   checks   = 0;
    int   failures = 0;
    bit   armed    = 0;

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (armed) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
            checks++;
            if ({Tx, busy, done} !== e) begin
                failures++;
                if (failures < 20)
                    $display("FAIL wave t=%0t tx/busy/done got %b%b%b want %b%b%b",
                             $time, Tx, busy, done, e.tx, e.busy, e.done);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_n(input bit tx, input bit bz, input int n);
        for (int i = 0; i < n; i++) mq.push_back('{tx: tx, busy: bz, done: 1'b0});
    endtask

    // Expected samples, one per edge starting at the edge that takes start
    task automatic build(input int addr, input int cnt);
        int a;
        logic [7:0] b;
        mq.delete();
        a = addr;
        if (cnt == 0) begin
            mq.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
        end else begin
            for (int k = 0; k < cnt; k++) begin
                b = ram[a];
                push_n(1'b1, 1'b1, 2);
                push_n(1'b0, 1'b1, L);
                for (int i = 0; i < 8; i++) push_n(b[i], 1'b1, L);
                push_n(1'b1, 1'b1, L * SB);
                a = (a + 1) % W;
            end
            mq.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
        end
        mq_end = a;
    endtask

    // Called on a negedge; returns on the following negedge
    task automatic start_block(input int addr, input int cnt);
        build(addr, cnt);
        start      = 1'b1;
        start_addr = 11'(addr);
        count      = 11'(cnt);
        if (exp_q.size() == 0)
            foreach (mq[i]) exp_q.push_back(mq[i]);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout waiting for block end, %0d samples left", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) ram[i] = 8'(i) ^ 8'h5c;
        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        count = '0;
        repeat (2) @(negedge clock);
        armed = 1;
        chk("reset_rdaddress", int'(rdaddress), 0);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        chk("idle_rdaddress", int'(rdaddress), 0);

        // single byte 0xA5
        ram[5] = 8'hA5;
        start_block(5, 1);
        chk("a5_len", mq.size(), 2 + 10 * L + 1);
        chk("a5_start_low", int'(mq[2].tx), 0);
        chk("a5_bit0", int'(mq[2 + L].tx), 1);
        chk("a5_bit1", int'(mq[2 + 2 * L].tx), 0);
        chk("a5_bit7", int'(mq[2 + 8 * L].tx), 1);
        chk("a5_done", int'(mq[2 + 10 * L].done), 1);
        wait_idle(2000);
        chk("a5_end_addr", int'(rdaddress), 6);

        // wrap across the end of the buffer
        ram[1998] = 8'h01;
        ram[1999] = 8'h80;
        ram[0]    = 8'hFF;
        start_block(1998, 3);
        chk("wrap_len", mq.size(), 3 * 492 + 1);
        chk("wrap_b0_bit0", int'(mq[2 + L].tx), 1);
        chk("wrap_b1_bit0", int'(mq[492 + 2 + L].tx), 0);
        chk("wrap_b1_bit7", int'(mq[492 + 2 + 8 * L].tx), 1);
        chk("wrap_b2_start", int'(mq[2 * 492 + 2].tx), 0);
        chk("wrap_b2_bit3", int'(mq[2 * 492 + 2 + 4 * L].tx), 1);
        chk("wrap_model_end", mq_end, 1);
        wait_idle(3000);
        chk("wrap_end_addr", int'(rdaddress), 1);

        // zero-length block
        start_block(7, 0);
        wait_idle(10);
        repeat (5) @(negedge clock);

        // start during a frame is ignored, then back-to-back after done
        ram[10] = 8'h3C;
        start_block(10, 1);
        repeat (100) @(negedge clock);
        start_block(40, 2);
        wait_idle(2000);
        ram[12] = 8'hC3;
        start_block(12, 1);
        wait_idle(2000);
        chk("b2b_end_addr", int'(rdaddress), 13);

        // reset in the middle of data bit 3
        ram[20] = 8'h5A;
        start_block(20, 1);
        repeat (215) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        chk("midreset_rdaddress", int'(rdaddress), 0);
        repeat (5) @(negedge clock);
        ram[30] = 8'h96;
        start_block(30, 1);
        wait_idle(2000);

        // 50 random bytes
        for (int i = 0; i < 50; i++) ram[100 + i] = 8'($urandom_range(0, 255));
        start_block(100, 50);
        wait_idle(30000);
        chk("rand_end_addr", int'(rdaddress), 150);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
